// File: rtl/pow_seq_if.sv
// Request/response bundle for pow_seq: operands and start request in,
// registered result, completion pulse and busy flag out.
interface pow_seq_if #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 5
);
    logic                 en;
    logic [WIDTH-1:0]     x;
    logic [EXP_WIDTH-1:0] e;
    logic [WIDTH-1:0]     out;
    logic                 valid;
    logic                 busy;

    modport master (output en, x, e, input out, valid, busy);
    modport slave  (input en, x, e, output out, valid, busy);
endinterface

// File: rtl/pow_seq.sv
// Sequential power unit: out = x^e mod 2^WIDTH by LSB-first square-and-multiply,
// one exponent bit per clock, result published with a one-cycle valid pulse.
module pow_seq #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 5
) (
    input  logic     clk,
    input  logic     rst,
    pow_seq_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     prod_rb;
    logic [WIDTH-1:0]     prod_bb;
    logic                 busy;

    // Products are sized to WIDTH, so the upper half is simply dropped.
    assign prod_rb = result_q * base_q;
    assign prod_bb = base_q * base_q;

    // NOTE: every register updates with <= so all of them see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= WIDTH'(1);
            base_q   <= '0;
            exp_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        // NOTE: assign a default before the case so no path infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.en) state_d = RUN;
            RUN:  if (exp_q == '0) state_d = IDLE;
        endcase
    end

    // Datapath next-state; en during RUN is ignored because only IDLE samples it.
    always_comb begin
        result_d = result_q;
        base_d   = base_q;
        exp_d    = exp_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    result_d = WIDTH'(1);
                    base_d   = bus.x;
                    exp_d    = bus.e;
                end
            end
            RUN: begin
                if (exp_q != '0) begin
                    if (exp_q[0]) result_d = prod_rb;
                    base_d = prod_bb;
                    exp_d  = exp_q >> 1;
                end else begin
                    out_d   = result_q;
                    valid_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy;

    // A completion always lands the machine back in IDLE.
    a_valid_idle: assert property (@(posedge clk) disable iff (rst)
        valid_q |-> (state_q == IDLE));

endmodule

// File: tb/tb_pow_seq.sv
// Bench for pow_seq: directed vector table, reset/ignore corner sequences and
// randomized operations against an arithmetic power model at two widths.
module tb_pow_seq;

    localparam int W0 = 32;
    localparam int E0 = 5;
    localparam int W1 = 8;
    localparam int E1 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pow_seq_if #(.WIDTH(W0), .EXP_WIDTH(E0)) bus32 ();
    pow_seq_if #(.WIDTH(W1), .EXP_WIDTH(E1)) bus8 ();

    pow_seq #(.WIDTH(W0), .EXP_WIDTH(E0)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    pow_seq #(.WIDTH(W1), .EXP_WIDTH(E1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0]     x;
        logic [4:0]      e;
        longint unsigned out;
        int              lat;
        bit              noise;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: repeated multiplication, reduced modulo 2^width each step.
    function automatic longint unsigned pow_ref(input longint unsigned x, input int e, input int width);
        longint unsigned mask = (64'd1 << width) - 64'd1;
        longint unsigned r    = 64'd1;
        for (int i = 0; i < e; i++) r = (r * (x & mask)) & mask;
        return r;
    endfunction

    function automatic int bitlen(input int e);
        int n = 0;
        while (e != 0) begin
            n++;
            e = e >> 1;
        end
        return n;
    endfunction

    task automatic op32(input logic [31:0] x, input logic [4:0] e, input longint unsigned exp_out,
                        input int exp_lat, input bit noise);
        int lat = 0;
        bus32.x  = x;
        bus32.e  = e;
        bus32.en = 1'b1;
        @(posedge clk); #1;
        check("accept_busy32", 64'(bus32.busy), 64'd1);
        check("accept_valid32", 64'(bus32.valid), 64'd0);
        bus32.en = noise;
        do begin
            bus32.x = $urandom;
            bus32.e = 5'($urandom);
            @(posedge clk); #1;
            lat++;
        end while (!bus32.valid && lat < E0 + 3);
        bus32.en = 1'b0;
        check("latency32", 64'(lat), 64'(exp_lat));
        check("valid32", 64'(bus32.valid), 64'd1);
        check("out32", 64'(bus32.out), exp_out);
        check("done_busy32", 64'(bus32.busy), 64'd0);
    endtask

    task automatic op8(input logic [7:0] x, input logic [2:0] e, input longint unsigned exp_out,
                       input int exp_lat);
        int lat = 0;
        bus8.x  = x;
        bus8.e  = e;
        bus8.en = 1'b1;
        @(posedge clk); #1;
        check("accept_busy8", 64'(bus8.busy), 64'd1);
        bus8.en = 1'b0;
        do begin
            bus8.x = 8'($urandom);
            bus8.e = 3'($urandom);
            @(posedge clk); #1;
            lat++;
        end while (!bus8.valid && lat < E1 + 3);
        check("latency8", 64'(lat), 64'(exp_lat));
        check("valid8", 64'(bus8.valid), 64'd1);
        check("out8", 64'(bus8.out), exp_out);
        check("done_busy8", 64'(bus8.busy), 64'd0);
    endtask

    task automatic idle32(input int n, input longint unsigned exp_out);
        repeat (n) begin
            @(posedge clk); #1;
            check("hold_out32", 64'(bus32.out), exp_out);
            check("hold_valid32", 64'(bus32.valid), 64'd0);
            check("hold_busy32", 64'(bus32.busy), 64'd0);
        end
    endtask

    initial begin
        logic [31:0]     rx;
        logic [4:0]      re;
        logic [7:0]      rx8;
        logic [2:0]      re8;
        longint unsigned last;

        tbl[0]  = '{32'd2,          5'd3,  64'd8,          3, 1'b0};
        tbl[1]  = '{32'd5,          5'd0,  64'd1,          1, 1'b0};
        tbl[2]  = '{32'd2,          5'd31, 64'h80000000,   6, 1'b0};
        tbl[3]  = '{32'hFFFFFFFF,   5'd31, 64'hFFFFFFFF,   6, 1'b0};
        tbl[4]  = '{32'd3,          5'd4,  64'd81,         4, 1'b1};
        tbl[5]  = '{32'd0,          5'd0,  64'd1,          1, 1'b0};
        tbl[6]  = '{32'd0,          5'd5,  64'd0,          4, 1'b0};
        tbl[7]  = '{32'd7,          5'd1,  64'd7,          2, 1'b1};
        tbl[8]  = '{32'd1,          5'd31, 64'd1,          6, 1'b0};
        tbl[9]  = '{32'd3,          5'd16, 64'd43046721,   6, 1'b0};
        tbl[10] = '{32'd16,         5'd8,  64'd0,          5, 1'b0};

        rst = 1'b0;
        bus32.en = 1'b0; bus32.x = '0; bus32.e = '0;
        bus8.en  = 1'b0; bus8.x  = '0; bus8.e  = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_out32", 64'(bus32.out), 64'd0);
        check("rst_valid32", 64'(bus32.valid), 64'd0);
        check("rst_busy32", 64'(bus32.busy), 64'd0);
        check("rst_out8", 64'(bus8.out), 64'd0);
        check("rst_busy8", 64'(bus8.busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // x=2, e=3: three busy cycles, one valid cycle, result then held.
        op32(32'd2, 5'd3, 64'd8, 3, 1'b0);
        idle32(2, 64'd8);

        // Table runs back-to-back: each start is requested in the previous valid cycle.
        foreach (tbl[i]) op32(tbl[i].x, tbl[i].e, tbl[i].out, tbl[i].lat, tbl[i].noise);
        idle32(1, tbl[10].out);

        // New request presented during RUN must be ignored.
        op32(32'd3, 5'd4, 64'd81, 4, 1'b1);
        idle32(1, 64'd81);

        // Abort mid-operation with an asynchronous reset between edges 2 and 3.
        bus32.x = 32'd2; bus32.e = 5'd16; bus32.en = 1'b1;
        @(posedge clk); #1;
        bus32.en = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_out", 64'(bus32.out), 64'd0);
        check("abort_valid", 64'(bus32.valid), 64'd0);
        check("abort_busy", 64'(bus32.busy), 64'd0);
        #1 rst = 1'b0;
        idle32(8, 64'd0);
        op32(32'd3, 5'd2, 64'd9, 3, 1'b0);

        // Randomized operations, 32-bit instance.
        last = 64'd9;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 7))
                0:       rx = 32'd0;
                1:       rx = 32'd1;
                2:       rx = 32'hFFFFFFFF;
                default: rx = $urandom;
            endcase
            re   = 5'($urandom);
            last = pow_ref(64'(rx), int'(re), W0);
            op32(rx, re, last, bitlen(int'(re)) + 1, bit'($urandom_range(0, 1)));
            idle32($urandom_range(0, 2), last);
        end

        // Randomized operations, 8-bit instance.
        for (int n = 0; n < 1000; n++) begin
            rx8 = 8'($urandom);
            re8 = 3'($urandom);
            op8(rx8, re8, pow_ref(64'(rx8), int'(re8), W1), bitlen(int'(re8)) + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
